// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, forwarding codes and select helper for hazard_ctrl
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // The younger producer (EX/MEM) wins over MEM/WB; r0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != 5'd0) begin
            if (mem_we && (mem_rd == src)) begin
                sel = FWD_EXMEM;
            end else if (wb_we && (wb_rd == src)) begin
                sel = FWD_MEMWB;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/forward_unit.sv
// rtl/forward_unit.sv - combinational EX operand forwarding selects
module forward_unit
    import hazard_pkg::*;
(
    input  logic [4:0] i_ex_rs,
    input  logic [4:0] i_ex_rt,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    assign o_fwd_a = fwd_sel(i_ex_rs, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);
    assign o_fwd_b = fwd_sel(i_ex_rt, i_mem_rd, i_mem_reg_write, i_wb_rd, i_wb_reg_write);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/flush/freeze sequencer with forwarding selects
// HAZARD_FORWARDING_EN enables EX forwarding; without it RAW hazards on EX/MEM producers stall.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             ex_redirect,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             hold_pc,
    output logic             hold_if_id,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int              TO_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic              r_rd_pend;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_stall_cycles;
    logic [CNT_W-1:0]  r_redirect_cnt;

    logic w_frz, w_load_use, w_raw, w_eval;
    logic w_redir_acc, w_to_inc, w_to_clr, w_pend_set, w_pend_clr;

    assign w_frz      = dmem_req & ~dmem_ready;
    assign w_load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0) &
                        ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));

`ifdef HAZARD_FORWARDING_EN
    assign w_raw = w_load_use;

    forward_unit u_forward_unit (
        .i_ex_rs         (ex_rs),
        .i_ex_rt         (ex_rt),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_reg_write),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_reg_write),
        .o_fwd_a         (fwd_a),
        .o_fwd_b         (fwd_b)
    );
`else
    // MEM/WB needs no stall: the register file writes through to the ID read.
    assign w_raw = w_load_use |
        (ex_reg_write & (ex_rd != 5'd0) &
         ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)))) |
        (mem_reg_write & (mem_rd != 5'd0) &
         ((id_uses_rs & (mem_rd == id_rs)) | (id_uses_rt & (mem_rd == id_rt))));

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;

    logic w_unused;
    assign w_unused = ^{ex_rs, ex_rt, wb_rd, wb_reg_write};
`endif

    always_comb begin
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        freeze       = 1'b0;
        w_next       = r_state;
        w_eval       = 1'b0;
        w_redir_acc  = 1'b0;
        w_to_inc     = 1'b0;
        w_to_clr     = 1'b0;
        w_pend_set   = 1'b0;
        w_pend_clr   = 1'b0;

        case (r_state)
            RUN: begin
                if (w_frz) begin
                    {freeze, hold_pc, hold_if_id} = 3'b111;
                    w_to_clr = 1'b1;
                    w_next   = MEM_WAIT;
                end else begin
                    w_eval = 1'b1;
                end
            end
            MEM_WAIT: begin
                // EX is held while frozen, so a redirect is re-presented on the exit cycle.
                if (!dmem_ready) begin
                    {freeze, hold_pc, hold_if_id} = 3'b111;
                    w_to_inc = 1'b1;
                end else begin
                    w_eval     = 1'b1;
                    w_pend_clr = 1'b1;
                    w_next     = r_rd_pend ? REDIRECT : RUN;
                end
            end
            REDIRECT: begin
                if (w_frz) begin
                    {freeze, hold_pc, hold_if_id} = 3'b111;
                    w_to_clr   = 1'b1;
                    w_pend_set = 1'b1;
                    w_next     = MEM_WAIT;
                end else begin
                    // The word returned on the imem_ready cycle is wrong-path and dropped too.
                    flush_if_id = 1'b1;
                    hold_pc     = 1'b1;
                    if (imem_ready) begin
                        w_next = RUN;
                    end
                end
            end
            default: w_next = RUN;
        endcase

        if (w_eval) begin
            if (ex_redirect) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                w_redir_acc  = 1'b1;
                if (!imem_ready) begin
                    w_next = REDIRECT;
                end
            end else if (w_raw) begin
                {hold_pc, hold_if_id, bubble_id_ex} = 3'b111;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= RUN;
            r_rd_pend      <= 1'b0;
            r_to_cnt       <= '0;
            r_timeout_err  <= 1'b0;
            r_stall_cycles <= '0;
            r_redirect_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_pend_set) begin
                r_rd_pend <= 1'b1;
            end else if (w_pend_clr) begin
                r_rd_pend <= 1'b0;
            end
            if (w_to_clr) begin
                r_to_cnt <= '0;
            end else if (w_to_inc && (r_to_cnt != TO_MAX)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_to_inc && (r_to_cnt == TO_MAX - 1'b1)) begin
                r_timeout_err <= 1'b1;
            end
            if (hold_pc && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (w_redir_acc && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + 1'b1;
            end
        end
    end

    assign mem_timeout_err = r_timeout_err;
    assign stall_cycles    = r_stall_cycles;
    assign redirect_cnt    = r_redirect_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (MEM_TIMEOUT=8)
module tb_hazard_ctrl;
    import hazard_pkg::*;

    localparam int CNT_W = 32;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    // {hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_LU    = 5'b11100;
    localparam logic [4:0] C_FRZ   = 5'b11001;
    localparam logic [4:0] C_RDR   = 5'b00110;
    localparam logic [4:0] C_RWAIT = 5'b10010;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic             id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
    logic             mem_reg_write, wb_reg_write, ex_redirect;
    logic             dmem_req, dmem_ready, imem_ready;
    logic             hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze;
    logic [1:0]       fwd_a, fwd_b;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles, redirect_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .ex_redirect(ex_redirect), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .imem_ready(imem_ready),
        .hold_pc(hold_pc), .hold_if_id(hold_if_id), .bubble_id_ex(bubble_id_ex),
        .flush_if_id(flush_if_id), .freeze(freeze), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles),
        .redirect_cnt(redirect_cnt)
    );

    typedef struct {
        string      tag;
        logic [4:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   exp_stall = 0;
    int   exp_redir = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        {id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd} = '0;
        {id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read} = '0;
        {mem_reg_write, wb_reg_write, ex_redirect} = '0;
        {dmem_req, dmem_ready, imem_ready} = '0;
    endtask

    // Inputs are already applied; compare at the falling edge, then cross one rising edge.
    task automatic step(input string tag, input logic [4:0] ctl,
                        input logic [1:0] fa = FWD_RF, input logic [1:0] fb = FWD_RF);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
        sb.push_back(e);
        if (rst_n && ctl[4]) exp_stall++;
        @(negedge clk);
        e = sb.pop_front();
        check_eq({e.tag, ".ctl"}, 32'({hold_pc, hold_if_id, bubble_id_ex, flush_if_id, freeze}),
                 32'(e.ctl));
        check_eq({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
        check_eq({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, ".stall_cycles"}, stall_cycles, 32'(exp_stall));
        check_eq({tag, ".redirect_cnt"}, redirect_cnt, 32'(exp_redir));
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        step("reset", C_NONE);
        check_counters("reset");
        check_eq("reset.err", 32'(mem_timeout_err), 32'd0);
        rst_n = 1'b1;

        // load-use on rs, then r0 never hazards, then load-use on rt
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        step("lu_rs", C_LU);
        clear_inputs();
        step("lu_done", C_NONE);
        check_eq("lu.stall_cycles", stall_cycles, 32'd1);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
        step("lu_r0", C_NONE);
        clear_inputs();
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9; id_rt = 9; id_uses_rt = 1;
        step("lu_rt", C_LU);
        id_uses_rt = 0;
        step("lu_rt_unused", C_NONE);

        // forwarding selects
        clear_inputs();
        ex_rs = 3; mem_rd = 3; mem_reg_write = 1; wb_rd = 3; wb_reg_write = 1;
        step("fwd_both", C_NONE, FWD_ON ? FWD_EXMEM : FWD_RF);
        mem_reg_write = 0;
        step("fwd_wb", C_NONE, FWD_ON ? FWD_MEMWB : FWD_RF);
        ex_rs = 0; wb_rd = 0;
        step("fwd_r0", C_NONE);
        ex_rt = 6; wb_rd = 6;
        step("fwd_b_wb", C_NONE, FWD_RF, FWD_ON ? FWD_MEMWB : FWD_RF);
        mem_rd = 6; mem_reg_write = 1;
        step("fwd_b_mem", C_NONE, FWD_RF, FWD_ON ? FWD_EXMEM : FWD_RF);

        // non-load RAW stalls only without forwarding
        clear_inputs();
        ex_rd = 7; ex_reg_write = 1; id_rt = 7; id_uses_rt = 1;
        step("raw_ex", FWD_ON ? C_NONE : C_LU);
        clear_inputs();
        mem_rd = 4; mem_reg_write = 1; id_rs = 4; id_uses_rs = 1;
        step("raw_mem", FWD_ON ? C_NONE : C_LU);
        clear_inputs();
        step("raw_done", C_NONE);
        check_counters("raw");

        // redirect across a slow instruction memory
        ex_redirect = 1; exp_redir++;
        step("rd0", C_RDR);
        ex_redirect = 0;
        step("rd1", C_RWAIT);
        step("rd2", C_RWAIT);
        imem_ready = 1;
        step("rd3", C_RWAIT);
        imem_ready = 0;
        step("rd_run", C_NONE);
        check_counters("redirect");

        // redirect with word ready stays in RUN; redirect outranks load-use
        ex_redirect = 1; imem_ready = 1; exp_redir++;
        step("rd_fast", C_RDR);
        ex_redirect = 0;
        step("rd_fast_run", C_NONE);
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
        ex_redirect = 1; exp_redir++;
        step("rd_over_lu", C_RDR);
        clear_inputs();

        // data-memory wait; redirect ignored while frozen
        dmem_req = 1;
        step("mw0", C_FRZ);
        ex_redirect = 1;
        step("mw1", C_FRZ);
        step("mw2", C_FRZ);
        step("mw3", C_FRZ);
        check_counters("mw_hold");
        dmem_ready = 1; imem_ready = 1; exp_redir++;
        step("mw_exit", C_RDR);
        clear_inputs();
        step("mw_run", C_NONE);
        check_counters("mw");

        // freeze while in REDIRECT leaves a pending redirect
        ex_redirect = 1; exp_redir++;
        step("rp0", C_RDR);
        ex_redirect = 0; dmem_req = 1;
        step("rp_frz0", C_FRZ);
        step("rp_frz1", C_FRZ);
        dmem_ready = 1;
        step("rp_exit", C_NONE);
        dmem_req = 0; dmem_ready = 0;
        step("rp_rd0", C_RWAIT);
        imem_ready = 1;
        step("rp_rd1", C_RWAIT);
        imem_ready = 0;
        step("rp_run", C_NONE);
        check_counters("rd_pend");

        // a short wait must not leave a partial timeout count behind
        dmem_req = 1;
        for (int i = 0; i < 6; i++) step("to_pre", C_FRZ);
        dmem_ready = 1;
        step("to_pre_exit", C_NONE);
        clear_inputs();
        check_eq("to_pre.err", 32'(mem_timeout_err), 32'd0);

        dmem_req = 1;
        step("to_entry", C_FRZ);
        for (int i = 0; i < 7; i++) step("to_wait", C_FRZ);
        check_eq("to_7.err", 32'(mem_timeout_err), 32'd0);
        step("to_wait8", C_FRZ);
        check_eq("to_8.err", 32'(mem_timeout_err), 32'd1);
        step("to_wait9", C_FRZ);
        step("to_wait10", C_FRZ);
        dmem_ready = 1;
        step("to_exit", C_NONE);
        clear_inputs();
        step("to_run", C_NONE);
        check_eq("to_sticky.err", 32'(mem_timeout_err), 32'd1);
        check_counters("timeout");

        // asynchronous reset out of MEM_WAIT
        dmem_req = 1;
        step("ar_entry", C_FRZ);
        step("ar_wait", C_FRZ);
        dmem_req = 0;
        #1;
        check_eq("ar_before.freeze", 32'(freeze), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_stall = 0; exp_redir = 0;
        check_eq("ar_after.freeze", 32'(freeze), 32'd0);
        check_eq("ar_after.hold_pc", 32'(hold_pc), 32'd0);
        check_eq("ar_after.err", 32'(mem_timeout_err), 32'd0);
        check_counters("ar_after");
        @(negedge clk);
        rst_n = 1'b1;
        step("ar_run", C_NONE);
        check_counters("ar_run");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencer for the 5-stage MIPS core: inspects the IF/ID, ID/EX, EX/MEM and MEM/WB register contents and drives the stall, bubble, flush and freeze controls of every pipeline register. It also drives the EX-stage operand forwarding selects, sequences taken-branch/jump redirects across a variable-latency instruction memory, and freezes the pipe during data-memory wait states. It sits beside the datapath; its outputs feed the PC, the IF/ID and ID/EX registers, the downstream pipeline registers and the EX operand muxes.

## Interface
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before `mem_timeout_err` is set.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- id_rs, id_rt  in  5 each  source registers of the instruction in IF/ID
- id_uses_rs, id_uses_rt  in  1 each  instruction in IF/ID reads rs/rt
- ex_rs, ex_rt  in  5 each  source registers held in ID/EX
- ex_rd  in  5  resolved destination in ID/EX
- ex_reg_write, ex_mem_read  in  1 each  ID/EX control bits
- mem_rd  in  5  EX/MEM destination
- mem_reg_write  in  1  EX/MEM control bit
- wb_rd  in  5  MEM/WB destination
- wb_reg_write  in  1  MEM/WB control bit
- ex_redirect  in  1  taken branch or jump resolved in EX
- dmem_req  in  1  MEM stage has an access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- imem_ready  in  1  instruction memory returns a word this cycle
- hold_pc  out  1  PC keeps its value
- hold_if_id  out  1  IF/ID keeps its value
- bubble_id_ex  out  1  ID/EX loads all-zero controls
- flush_if_id  out  1  IF/ID loads a NOP
- freeze  out  1  ID/EX, EX/MEM and MEM/WB hold their values
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- mem_timeout_err  out  1  sticky error flag
- stall_cycles, redirect_cnt  out  CNT_W each  performance counters

## Operation
- States: RUN, MEM_WAIT, REDIRECT. A pending-redirect bit `rd_pend` is kept alongside the state.
- Register 0 never matches in any hazard or forwarding comparison.
- Load-use hazard: `ex_mem_read & ex_reg_write & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt))`. On a hazard, assert hold_pc, hold_if_id and bubble_id_ex.
- Forwarding applies to both fwd_a and fwd_b, using ex_rs and ex_rt respectively. An EX/MEM match (mem_reg_write) gives 01. An MEM/WB match (wb_reg_write) gives 10. A match in both gives 01.
- Priority, highest first: freeze > redirect > load-use.
- RUN:
  - If `dmem_req & !dmem_ready`: assert freeze, hold_pc and hold_if_id; go to MEM_WAIT.
  - Else if ex_redirect: assert flush_if_id and bubble_id_ex. If !imem_ready, go to REDIRECT; otherwise stay in RUN.
- MEM_WAIT:
  - While !dmem_ready: assert freeze, hold_pc and hold_if_id, and increment the timeout counter.
  - On dmem_ready: release freeze and evaluate ex_redirect exactly as in RUN. Go to REDIRECT if a redirect is needed or rd_pend is set; otherwise go to RUN.
  - ex_redirect is ignored while frozen, because EX is held and the redirect is re-presented on the exit cycle.
- REDIRECT:
  - Assert flush_if_id and hold_pc every cycle, including the imem_ready cycle. That returned word belongs to the squashed path and is dropped.
  - After the imem_ready cycle, go to RUN.
  - If `dmem_req & !dmem_ready` occurs here, set rd_pend and go to MEM_WAIT.
- Timeout: when the counter reaches MEM_TIMEOUT, set mem_timeout_err and hold it until reset. The FSM stays in MEM_WAIT. The counter clears on every MEM_WAIT entry.
- Counters:
  - stall_cycles increments on every cycle with hold_pc=1.
  - redirect_cnt increments once per accepted ex_redirect.
  - Both saturate at all-ones.

## Timing
- All control outputs are combinational from the inputs and the current state, so they are valid in the same cycle. The state, rd_pend, the timeout counter and the performance counters are registered.
- Load-use costs exactly 1 bubble. A redirect with imem_ready=1 in the same cycle costs 2 squashed slots. Each REDIRECT cycle adds 1 further slot.
- Reset values: state RUN, rd_pend 0, timeout counter 0, mem_timeout_err 0, both counters 0, fwd 00. With all inputs at 0, every control output is 0.
- Reset asserted mid-operation, in any state, returns to RUN the same instant.

## Configuration
- HAZARD_FORWARDING_EN defined: forwarding as described above.
- Undefined:
  - fwd_a and fwd_b are tied to 00.
  - The ID-stage RAW stall is widened to any match of id_rs/id_rt with ex_rd (ex_reg_write) or mem_rd (mem_reg_write).
  - MEM/WB needs no stall because the register file is write-through.

## Structure
- Package `hazard_pkg`: state enum (RUN, MEM_WAIT, REDIRECT) and fwd codes FWD_RF/FWD_EXMEM/FWD_MEMWB.
- Sub-module `forward_unit`: purely combinational, computes fwd_a and fwd_b. It is instantiated only under HAZARD_FORWARDING_EN.

## Test plan
- Load-use: ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> hold_pc, hold_if_id, bubble_id_ex all 1 for one cycle; stall_cycles=1.
- Forwarding: ex_rs=3, mem_rd=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1 -> fwd_a=01. Same with mem_reg_write=0 -> fwd_a=10. ex_rs=0 -> fwd_a=00.
- Redirect: ex_redirect=1 with imem_ready=0 for 3 cycles, then 1 -> flush_if_id=1 for 4 cycles; state REDIRECT→RUN; redirect_cnt=1.
- Memory wait: dmem_req=1, dmem_ready=0 for 4 cycles -> freeze=1 for 4 cycles; ex_redirect=1 during the wait is ignored until the dmem_ready cycle.
- Timeout: MEM_TIMEOUT=8, dmem_ready never asserted -> mem_timeout_err=1 after 8 wait cycles and stays 1; rst_n low clears everything.
- Macro off: ex_rd=7, ex_reg_write=1, ex_mem_read=0, id_rt=7, id_uses_rt=1 -> 1-cycle stall; fwd_a and fwd_b stay 00.
